sbus_frame_decoder: RTL and testbench
=====================================

Name: sbus_frame_decoder

Overview:
- Consumes the 11-bit character stream from uart_rx (8 data + parity + 2 stop, 100 kbit/s Futaba S.Bus) and assembles 25-byte S.Bus frames: header 0x0F, 22 packed data bytes (16 channels x 11 bits), flags byte, end byte.
- Unpacks the data bytes into 16 channel values.
- On a good frame, commits the channels and flags atomically to an output bank and pulses frame_valid.
- Bad, short or gapped frames are discarded with an error pulse.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- GAP_CYCLES, 12500, idle threshold in clocks (250 us); used for header qualification and the mid-frame timeout.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- uart_rx_valid  in  1  one-cycle strobe, character available.
- uart_rx_data  in  11  character; [7:0] byte, [8] parity, [10:9] stop.
- uart_rx_pe  in  1  parity error, qualified by uart_rx_valid.
- uart_rx_fe  in  1  frame error, qualified by uart_rx_valid.
- uart_rx_break  in  1  break detected (level or pulse).
- ch_sel  in  4  channel read address.
- ch_data  out  11  committed channel[ch_sel], combinational read.
- ch17  out  1  flags bit0, committed.
- ch18  out  1  flags bit1, committed.
- frame_lost  out  1  flags bit2, committed.
- failsafe  out  1  flags bit3, committed.
- frame_valid  out  1  one-cycle pulse, new frame committed.
- frame_err  out  1  one-cycle pulse, frame aborted.
- err_code  out  2  cause of last abort: 0 char error/break, 1 timeout, 2 bad end byte; held until the next abort.

Behaviour:
- Reset (async, resetn=0): state IDLE. All 16 bank entries 0. Flags 0, frame_valid 0, frame_err 0, err_code 0. Gap counter 0, accumulator and bit count 0.
- A "byte" is uart_rx_valid=1. Only uart_rx_data[7:0] is decoded; bits [10:8] are ignored (uart_rx checks them).
- Gap counter:
  - clears to 0 on every byte;
  - otherwise increments, saturating at GAP_CYCLES;
  - "gap_ok" = counter == GAP_CYCLES.
- IDLE:
  - byte 0x0F with gap_ok=1 and no pe/fe -> DATA; clear accumulator, acc_bits=0, ch_idx=0.
  - any other byte is ignored, with no error pulse.
  - a 0x0F without a preceding gap is not a header (resync rule).
- DATA, per byte (22 bytes):
  - acc |= byte << acc_bits; acc_bits += 8.
  - if the new acc_bits >= 11: shadow[ch_idx] = acc[10:0], acc >>= 11, acc_bits -= 11, ch_idx++.
  - accumulator is 19 bits; acc_bits never exceeds 18.
  - after byte 22: ch_idx == 16 and acc_bits == 0 -> FLAGS.
- FLAGS: next byte latched into shadow_flags[3:0]; bits [7:4] are ignored -> END.
- END: byte 0x00 -> commit shadow bank and flags to the outputs on the same clock edge; frame_valid=1 on the following cycle (one-cycle latency from the end byte's uart_rx_valid); -> IDLE. Any other value -> abort, code 2.
- Abort conditions in DATA/FLAGS/END:
  - byte with pe or fe, or uart_rx_break=1 -> abort, code 0.
  - gap counter reaching GAP_CYCLES -> abort, code 1.
- Abort: frame_err pulses 1 cycle; err_code updated; -> IDLE. The committed bank and flags are unchanged, so a partial frame never reaches the outputs.
- Break in IDLE: ignored.
- Simultaneous events:
  - uart_rx_valid in the same cycle the timeout would fire: the byte wins and the counter clears.
  - pe/fe on the end byte: abort code 0, no commit.
- ch_data reads are never torn: the commit is a single-edge copy.
- Async reset mid-frame: everything returns to reset values immediately; the next frame needs a full gap.

Optional Feature:
- Macro SBUS2_EN.
- Defined: END also accepts end bytes 0x04, 0x14, 0x24, 0x34 (S.Bus2 telemetry slots) and commits normally. Output slot_id (2 bits) = end byte [5:4] for 0x?4 end bytes, 0 for 0x00, updated at commit, reset 0.
- Undefined: only 0x00 is accepted, and the slot_id port does not exist.

Test Plan:
- Reset, 300 us idle, then a frame: 0x0F; data byte1=0xF8, byte2=0x3F, all other data bytes 0x00; flags 0x0C; end 0x00. Required: frame_valid pulses once; ch_sel=1 gives 0x7FF; all other channels give 0; failsafe=1, frame_lost=1, ch17=0, ch18=0.
- Frame with all 22 data bytes 0xFF, flags 0x03. Required: every channel 0x7FF, ch17=1, ch18=1, frame_valid 1 cycle after the end strobe.
- Frame with uart_rx_pe=1 on data byte 10. Required: frame_err pulse, err_code=0, bank still holds the previous frame's values, no frame_valid.
- Stop after data byte 5 for 300 us. Required: frame_err with err_code=1 at GAP_CYCLES; the next gapped 0x0F frame decodes correctly.
- End byte 0x04. Required without SBUS2_EN: err_code=2, no commit. Required with SBUS2_EN: commit, slot_id=0.
- 0x0F sent 120 us after a previous byte (no gap). Required: ignored, no frame_valid and no frame_err for the following 24 bytes.

Source files
------------

// File: rtl/sbus_frame_decoder.sv
// S.Bus frame decoder: assembles 25-byte frames from uart_rx characters into a committed channel bank.
// Optional S.Bus2 telemetry end bytes and slot_id output are enabled with `define SBUS2_EN.
module sbus_frame_decoder #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned GAP_CYCLES = 12500
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        uart_rx_valid,
    input  logic [10:0] uart_rx_data,
    input  logic        uart_rx_pe,
    input  logic        uart_rx_fe,
    input  logic        uart_rx_break,
    input  logic [3:0]  ch_sel,
    output logic [10:0] ch_data,
    output logic        ch17,
    output logic        ch18,
    output logic        frame_lost,
    output logic        failsafe,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [1:0]  err_code
`ifdef SBUS2_EN
    ,
    output logic [1:0]  slot_id
`endif
);

    // A zero gap falls back to 250 us derived from the clock.
    localparam int unsigned GAP = (GAP_CYCLES != 0) ? GAP_CYCLES : CLK_HZ / 4000;
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {IDLE, DATA, FLAGS, ENDB} state_t;

    state_t        state;
    logic [GW-1:0] gap_cnt;
    logic          gap_ok;
    logic [7:0]    rx_byte;
    logic          char_bad;
    logic          end_ok;
    logic [18:0]   acc;
    logic [18:0]   acc_sum;
    logic [4:0]    acc_bits;
    logic [4:0]    bits_sum;
    logic [4:0]    ch_idx;
    logic [10:0]   shadow [16];
    logic [10:0]   bank [16];
    logic [3:0]    shadow_flags;
    logic [3:0]    flags;
    logic          unused_bits;

    assign rx_byte     = uart_rx_data[7:0];
    assign unused_bits = ^uart_rx_data[10:8];
    assign char_bad    = uart_rx_pe | uart_rx_fe;
    assign gap_ok      = (gap_cnt == GW'(GAP));

`ifdef SBUS2_EN
    assign end_ok = (rx_byte == 8'h00) ||
                    (rx_byte[7:6] == 2'b00 && rx_byte[3:0] == 4'h4);
`else
    assign end_ok = (rx_byte == 8'h00);
`endif

    always_comb begin
        acc_sum  = acc | (19'(rx_byte) << acc_bits);
        bits_sum = acc_bits + 5'd8;
    end

    assign ch_data    = bank[ch_sel];
    assign ch17       = flags[0];
    assign ch18       = flags[1];
    assign frame_lost = flags[2];
    assign failsafe   = flags[3];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            acc          <= '0;
            acc_bits     <= '0;
            ch_idx       <= '0;
            shadow_flags <= '0;
            flags        <= '0;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
            err_code     <= 2'd0;
`ifdef SBUS2_EN
            slot_id      <= 2'd0;
`endif
            for (int i = 0; i < 16; i++) begin
                shadow[i] <= '0;
                bank[i]   <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (uart_rx_valid)
                gap_cnt <= '0;
            else if (!gap_ok)
                gap_cnt <= gap_cnt + 1'b1;

            unique case (state)
                IDLE: begin
                    if (uart_rx_valid && !char_bad && gap_ok && rx_byte == 8'h0F) begin
                        state    <= DATA;
                        acc      <= '0;
                        acc_bits <= '0;
                        ch_idx   <= '0;
                    end
                end
                default: begin
                    if (uart_rx_break || (uart_rx_valid && char_bad)) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                        err_code  <= 2'd0;
                    end else if (uart_rx_valid) begin
                        case (state)
                            DATA: begin
                                // Each 11-bit channel completes once 11 bits are buffered.
                                if (bits_sum >= 5'd11) begin
                                    shadow[ch_idx[3:0]] <= acc_sum[10:0];
                                    acc      <= acc_sum >> 11;
                                    acc_bits <= bits_sum - 5'd11;
                                    ch_idx   <= ch_idx + 5'd1;
                                    if (ch_idx == 5'd15)
                                        state <= FLAGS;
                                end else begin
                                    acc      <= acc_sum;
                                    acc_bits <= bits_sum;
                                end
                            end
                            FLAGS: begin
                                shadow_flags <= rx_byte[3:0];
                                state        <= ENDB;
                            end
                            default: begin
                                state <= IDLE;
                                if (end_ok) begin
                                    for (int i = 0; i < 16; i++)
                                        bank[i] <= shadow[i];
                                    flags       <= shadow_flags;
                                    frame_valid <= 1'b1;
`ifdef SBUS2_EN
                                    slot_id     <= rx_byte[5:4];
`endif
                                end else begin
                                    frame_err <= 1'b1;
                                    err_code  <= 2'd2;
                                end
                            end
                        endcase
                    end else if (gap_ok) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                        err_code  <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbus_frame_decoder.sv
// Bench for sbus_frame_decoder: table of frames, event scoreboard, bit-level channel model.
module tb_sbus_frame_decoder;

    localparam int GAP = 100;
    localparam logic [7:0] NONE = 8'hFF;
    localparam logic [1:0] K_OK = 2'd0, K_ERR = 2'd1, K_NONE = 2'd2;

    typedef struct packed {
        logic             gap;
        logic [21:0][7:0] data;
        logic [7:0]       flags;
        logic [7:0]       endb;
        logic [7:0]       pe_at;
        logic [7:0]       stop_at;
        logic [7:0]       brk_at;
        logic [1:0]       kind;
        logic [1:0]       code;
    } frame_t;

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] code;
    } ev_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rx_valid = 1'b0;
    logic [10:0] rx_data = '0;
    logic        rx_pe = 1'b0;
    logic        rx_fe = 1'b0;
    logic        brk = 1'b0;
    logic [3:0]  ch_sel = '0;
    logic [10:0] ch_data;
    logic        ch17, ch18, frame_lost, failsafe;
    logic        frame_valid, frame_err;
    logic [1:0]  err_code;
`ifdef SBUS2_EN
    logic [1:0]  slot_id;
    logic [1:0]  exp_slot = 2'd0;
`endif

    int          n_vec = 0;
    int          n_mis = 0;
    ev_t         q[$];
    logic [1:0]  last_code = 2'd0;
    logic [10:0] exp_bank [16];
    logic [3:0]  exp_flags = '0;
    frame_t      vecs [10];

    sbus_frame_decoder #(.CLK_HZ(50000000), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .resetn(resetn),
        .uart_rx_valid(rx_valid), .uart_rx_data(rx_data),
        .uart_rx_pe(rx_pe), .uart_rx_fe(rx_fe), .uart_rx_break(brk),
        .ch_sel(ch_sel), .ch_data(ch_data),
        .ch17(ch17), .ch18(ch18), .frame_lost(frame_lost), .failsafe(failsafe),
        .frame_valid(frame_valid), .frame_err(frame_err), .err_code(err_code)
`ifdef SBUS2_EN
        , .slot_id(slot_id)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Channel c bit k is stream bit c*11+k, bytes LSB first.
    function automatic logic [10:0] model_ch(input logic [21:0][7:0] d, input int c);
        logic [10:0] r;
        int b;
        r = '0;
        for (int k = 0; k < 11; k++) begin
            b = c * 11 + k;
            r[k] = d[b / 8][b % 8];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        ev_t e;
        if (resetn && (frame_valid || frame_err)) begin
            n_vec++;
            if (q.size() == 0) begin
                n_mis++;
                $display("FAIL unexpected_event valid=%0b err=%0b code=%0d", frame_valid, frame_err, err_code);
            end else begin
                e = q.pop_front();
                if (frame_valid !== (e.kind == K_OK) || frame_err !== (e.kind == K_ERR) ||
                    (e.kind == K_ERR && err_code !== e.code)) begin
                    n_mis++;
                    $display("FAIL event got v=%0b e=%0b code=%0d want kind=%0d code=%0d",
                             frame_valid, frame_err, err_code, e.kind, e.code);
                end
                if (e.kind == K_ERR) last_code = e.code;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic pe);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = {2'b11, ^b, b};
        rx_pe    = pe;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_pe    = 1'b0;
    endtask

    task automatic send_frame(input frame_t v);
        logic [7:0] b;
        if (v.gap) repeat (GAP + 10) @(negedge clk);
        else begin
            send_byte(8'h00, 1'b0);
            repeat (GAP * 6 / 10) @(negedge clk);
        end
        if (v.kind != K_NONE) q.push_back('{kind: v.kind, code: v.code});
        send_byte(8'h0F, 1'b0);
        for (int i = 0; i < 24; i++) begin
            if (i == int'(v.stop_at)) return;
            if (i == int'(v.brk_at)) begin
                @(negedge clk);
                brk = 1'b1;
                @(negedge clk);
                brk = 1'b0;
                return;
            end
            b = (i < 22) ? v.data[i] : ((i == 22) ? v.flags : v.endb);
            send_byte(b, i == int'(v.pe_at));
            if (i == int'(v.pe_at)) return;
            if (i == 23 && v.kind == K_OK) chk("valid_latency", frame_valid, 1);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 4 * GAP && q.size() != 0; t++) @(negedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL event_timeout got=%0d pending want=0", q.size());
            q.delete();
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic check_bank(input string tag);
        for (int c = 0; c < 16; c++) begin
            ch_sel = 4'(c);
            #1;
            chk($sformatf("%s_ch%0d", tag, c), ch_data, exp_bank[c]);
        end
        chk({tag, "_flags"}, {failsafe, frame_lost, ch18, ch17}, exp_flags);
        chk({tag, "_err_code"}, err_code, last_code);
`ifdef SBUS2_EN
        chk({tag, "_slot"}, slot_id, exp_slot);
`endif
    endtask

    task automatic run_vec(input frame_t v, input string tag);
        send_frame(v);
        drain();
        if (v.kind == K_OK) begin
            for (int c = 0; c < 16; c++) exp_bank[c] = model_ch(v.data, c);
            exp_flags = v.flags[3:0];
`ifdef SBUS2_EN
            exp_slot = v.endb[5:4];
`endif
        end
        check_bank(tag);
    endtask

    initial begin
        frame_t base;
        logic [1:0] k5, c5;
`ifdef SBUS2_EN
        k5 = K_OK;  c5 = 2'd0;
`else
        k5 = K_ERR; c5 = 2'd2;
`endif
        base = '{gap: 1'b1, data: '0, flags: 8'h00, endb: 8'h00, pe_at: NONE,
                 stop_at: NONE, brk_at: NONE, kind: K_OK, code: 2'd0};
        for (int i = 0; i < 10; i++) vecs[i] = base;
        vecs[0].data[1] = 8'hF8;
        vecs[0].data[2] = 8'h3F;
        vecs[0].flags   = 8'h0C;
        vecs[1].flags   = 8'h03;
        vecs[2].pe_at   = 8'd10;
        vecs[2].kind    = K_ERR;
        vecs[3].stop_at = 8'd5;
        vecs[3].kind    = K_ERR;
        vecs[3].code    = 2'd1;
        vecs[4].flags   = 8'hF5;
        vecs[5].flags   = 8'h0A;
        vecs[5].endb    = 8'h04;
        vecs[5].kind    = k5;
        vecs[5].code    = c5;
        vecs[6].endb    = 8'h55;
        vecs[6].kind    = K_ERR;
        vecs[6].code    = 2'd2;
        vecs[7].brk_at  = 8'd7;
        vecs[7].kind    = K_ERR;
        vecs[8].gap     = 1'b0;
        vecs[8].kind    = K_NONE;
        vecs[9].pe_at   = 8'd23;
        vecs[9].kind    = K_ERR;
        for (int i = 0; i < 22; i++) begin
            vecs[1].data[i] = 8'hFF;
            vecs[2].data[i] = 8'(i * 13);
            vecs[3].data[i] = 8'(i * 13);
            vecs[4].data[i] = 8'(i * 29 + 7);
            vecs[5].data[i] = 8'(i * 5 + 1);
            vecs[6].data[i] = 8'h11;
            vecs[7].data[i] = 8'(i);
            vecs[8].data[i] = 8'(i * 3);
            vecs[9].data[i] = 8'hA5;
        end
        for (int c = 0; c < 16; c++) exp_bank[c] = '0;

        repeat (3) @(negedge clk);
        chk("rst_valid", frame_valid, 0);
        chk("rst_err", frame_err, 0);
        check_bank("rst");
        resetn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
            if (i == 0) begin
                ch_sel = 4'd1;
                #1;
                chk("v0_ch1_const", ch_data, 11'h7FF);
                chk("v0_failsafe", failsafe, 1);
                chk("v0_frame_lost", frame_lost, 1);
            end
        end

        send_byte(8'h00, 1'b0);
        repeat (GAP + 10) @(negedge clk);
        send_byte(8'h0F, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        q.delete();
        last_code = 2'd0;
        exp_flags = '0;
        for (int c = 0; c < 16; c++) exp_bank[c] = '0;
`ifdef SBUS2_EN
        exp_slot = 2'd0;
`endif
        chk("midrst_valid", frame_valid, 0);
        check_bank("midrst");
        @(negedge clk);
        resetn = 1'b1;
        vecs[8].kind = K_NONE;
        run_vec(vecs[8], "post_rst_nogap");
        run_vec(vecs[4], "post_rst_gap");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
